// File: rtl/lcd_value_writer.sv
// Prints a 16-bit value as five ASCII digits on the LCD via the I2C byte master.
// Define LCD_ZERO_BLANK_EN to send leading zero digits as spaces.
module lcd_value_writer #(
    parameter logic [7:0] LCD_ADDR  = 8'h7c,
    parameter logic [6:0] DDRAM_POS = 7'h00,
    parameter logic [7:0] END_WAIT  = 8'd16
) (
    input  logic        ioclk,
    input  logic        res,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        ready,
    output logic        write,
    output logic        send,
    output logic        start,
    output logic        endcomm,
    output logic [7:0]  tx_byte,
    input  logic        done
);

    typedef enum logic [2:0] {
        IDLE, CONVERT, START, WAIT_DONE,
        LOAD, SEND, STOP, STOP_WAIT
    } state_t;

    state_t      state, state_d;
    logic [15:0] shreg, shreg_d;
    logic [19:0] bcd, bcd_d, bcd_adj;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [3:0]  idx, idx_d;
    logic [1:0]  guard, guard_d;
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic        ready_d, write_d, send_d;
    logic        start_d, endcomm_d;
    logic [7:0]  byte_d, table_byte;
    logic [4:1]  blank;

    // double-dabble correction applied before each shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef LCD_ZERO_BLANK_EN
    always_comb begin
        blank    = '0;
        blank[4] = (bcd[19:16] == 4'd0);
        blank[3] = blank[4] && (bcd[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        table_byte = 8'h00;
        unique case (idx)
            4'd0: table_byte = LCD_ADDR;
            4'd1: table_byte = 8'h80;
            4'd2: table_byte = {1'b1, DDRAM_POS};
            4'd3: table_byte = 8'h40;
            4'd4: table_byte = blank[4] ? 8'h20 : {4'h3, bcd[19:16]};
            4'd5: table_byte = blank[3] ? 8'h20 : {4'h3, bcd[15:12]};
            4'd6: table_byte = blank[2] ? 8'h20 : {4'h3, bcd[11:8]};
            4'd7: table_byte = blank[1] ? 8'h20 : {4'h3, bcd[7:4]};
            4'd8: table_byte = {4'h3, bcd[3:0]};
            default: table_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bcd_d      = bcd;
        bit_cnt_d  = bit_cnt;
        idx_d      = idx;
        guard_d    = guard;
        wait_cnt_d = wait_cnt;
        byte_d     = tx_byte;
        ready_d    = 1'b0;
        write_d    = 1'b0;
        send_d     = 1'b0;
        start_d    = 1'b0;
        endcomm_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (value_valid && ready) begin
                    shreg_d   = value;
                    bcd_d     = '0;
                    bit_cnt_d = 4'd0;
                    idx_d     = 4'd0;
                    state_d   = CONVERT;
                end else begin
                    ready_d = 1'b1;
                end
            end
            CONVERT: begin
                bcd_d     = {bcd_adj[18:0], shreg[15]};
                shreg_d   = {shreg[14:0], 1'b0};
                bit_cnt_d = bit_cnt + 4'd1;
                if (bit_cnt == 4'd15)
                    state_d = START;
            end
            START: begin
                start_d = 1'b1;
                guard_d = 2'd0;
                state_d = WAIT_DONE;
            end
            // the master's done is stale for two cycles after a pulse
            WAIT_DONE: begin
                if (guard != 2'd2)
                    guard_d = guard + 2'd1;
                else if (done)
                    state_d = (idx == 4'd9) ? STOP : LOAD;
            end
            LOAD: begin
                byte_d  = table_byte;
                write_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                send_d  = 1'b1;
                idx_d   = idx + 4'd1;
                guard_d = 2'd0;
                state_d = WAIT_DONE;
            end
            STOP: begin
                endcomm_d  = 1'b1;
                wait_cnt_d = 8'd0;
                state_d    = STOP_WAIT;
            end
            STOP_WAIT: begin
                wait_cnt_d = wait_cnt + 8'd1;
                if (wait_cnt == END_WAIT - 8'd1) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ioclk) begin
        if (!res) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            guard    <= '0;
            wait_cnt <= '0;
            tx_byte  <= 8'h00;
            ready    <= 1'b0;
            write    <= 1'b0;
            send     <= 1'b0;
            start    <= 1'b0;
            endcomm  <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bcd      <= bcd_d;
            bit_cnt  <= bit_cnt_d;
            idx      <= idx_d;
            guard    <= guard_d;
            wait_cnt <= wait_cnt_d;
            tx_byte  <= byte_d;
            ready    <= ready_d;
            write    <= write_d;
            send     <= send_d;
            start    <= start_d;
            endcomm  <= endcomm_d;
        end
    end

endmodule

// File: tb/tb_lcd_value_writer.sv
// Bench for lcd_value_writer: master model, protocol monitor and
// decimal reference model checked with immediate assertions.
module tb_lcd_value_writer;

    localparam logic [7:0] P_ADDR = 8'h7c;
    localparam logic [6:0] P_POS  = 7'h40;
    localparam logic [7:0] P_WAIT = 8'd16;
    localparam int         DLY    = 20;

    logic        ioclk = 1'b0;
    logic        res = 1'b0;
    logic [15:0] value = '0;
    logic        value_valid = 1'b0;
    logic        done = 1'b1;
    logic        ready, write, send, start, endcomm;
    logic [7:0]  tx_byte;

    lcd_value_writer #(
        .LCD_ADDR(P_ADDR),
        .DDRAM_POS(P_POS),
        .END_WAIT(P_WAIT)
    ) dut (
        .ioclk(ioclk),
        .res(res),
        .value(value),
        .value_valid(value_valid),
        .ready(ready),
        .write(write),
        .send(send),
        .start(start),
        .endcomm(endcomm),
        .tx_byte(tx_byte),
        .done(done)
    );

    always #5 ioclk = ~ioclk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int n_start, n_write, n_send, n_end;
    int start_cyc, end_cyc, rdy_cyc;
    logic [7:0] got[$];
    int wr_cyc[$];
    int sd_cyc[$];
    bit done_hold = 1'b0;
    int dcnt = 0;
    logic prev_write = 1'b0;
    logic prev_ready = 1'b0;
    logic [7:0] prev_byte = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [15:0] v,
                                            input int i);
        int x;
        int p;
        int pw;
        x = int'(v);
        case (i)
            0: return P_ADDR;
            1: return 8'h80;
            2: return {1'b1, P_POS};
            3: return 8'h40;
            default: begin
                p = 8 - i;
                pw = 1;
                for (int k = 0; k < p; k++) pw = pw * 10;
`ifdef LCD_ZERO_BLANK_EN
                if (p > 0 && x < pw) return 8'h20;
`endif
                return 8'(8'h30 + (x / pw) % 10);
            end
        endcase
    endfunction

    task automatic clear_rec();
        n_start = 0; n_write = 0; n_send = 0; n_end = 0;
        start_cyc = -1; end_cyc = -1; rdy_cyc = -1;
        got.delete(); wr_cyc.delete(); sd_cyc.delete();
    endtask

    initial forever begin
        @(posedge ioclk);
        cyc++;
    end

    // I2C master model: done drops on start/send, rises DLY cycles later
    initial forever begin
        @(posedge ioclk);
        #1;
        if (done_hold) begin
            done = 1'b1;
        end else if (start || send) begin
            done = 1'b0;
            dcnt = DLY;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) done = 1'b1;
        end
    end

    initial forever begin
        @(posedge ioclk);
        #1;
        if (res) begin
            if (start || write || send || endcomm)
                chk("onehot", $countones({start, write, send, endcomm}), 1);
            if (prev_write) begin
                chk("send_after_write", send, 1);
                chk("byte_hold", tx_byte, prev_byte);
            end
            if (send) chk("write_before_send", prev_write, 1);
            if (start) begin n_start++; start_cyc = cyc; end
            if (write) begin
                n_write++;
                got.push_back(tx_byte);
                wr_cyc.push_back(cyc);
            end
            if (send) begin n_send++; sd_cyc.push_back(cyc); end
            if (endcomm) begin n_end++; end_cyc = cyc; end
            if (ready && !prev_ready) rdy_cyc = cyc;
        end
        prev_write = write && res;
        prev_byte  = tx_byte;
        prev_ready = ready;
    end

    task automatic run_txn(input logic [15:0] v, input bit inject);
        int t;
        int acc;
        clear_rec();
        t = 0;
        @(negedge ioclk);
        while (!ready && t < 3000) begin @(negedge ioclk); t++; end
        chk("ready_before", ready, 1);
        value = v;
        value_valid = 1'b1;
        acc = cyc + 1;
        @(negedge ioclk);
        value_valid = 1'b0;
        value = 16'($urandom);
        if (inject) begin
            repeat (40) @(negedge ioclk);
            value = 16'd999;
            value_valid = 1'b1;
            repeat (3) @(negedge ioclk);
            value_valid = 1'b0;
        end
        t = 0;
        while (!ready && t < 5000) begin @(negedge ioclk); t++; end
        chk("ready_after", ready, 1);
        chk("n_start", n_start, 1);
        chk("n_write", n_write, 9);
        chk("n_send", n_send, 9);
        chk("n_endcomm", n_end, 1);
        chk("start_latency", start_cyc - acc, 17);
        chk("ready_latency", rdy_cyc - end_cyc, int'(P_WAIT));
        for (int i = 0; i < 9; i++)
            chk($sformatf("byte%0d v=%0d", i, v),
                (i < got.size()) ? got[i] : 8'hxx, exp_byte(v, i));
    endtask

    initial begin
        int t;
        clear_rec();
        repeat (3) begin
            @(negedge ioclk);
            chk("reset_pulses", {ready, start, write, send, endcomm}, 0);
            chk("reset_byte", tx_byte, 0);
        end
        res = 1'b1;
        @(negedge ioclk);
        chk("ready_after_reset", ready, 1);
        repeat (5) @(negedge ioclk);
        chk("idle_no_start", n_start + n_write + n_send + n_end, 0);

        run_txn(16'd12345, 1'b0);
        run_txn(16'hFFFF, 1'b0);
        run_txn(16'd0, 1'b0);
        run_txn(16'd7, 1'b0);
        run_txn(16'($urandom), 1'b1);
        repeat (4) run_txn(16'($urandom), 1'b0);
        repeat (3) run_txn(16'($urandom_range(0, 999)), 1'b0);

        done_hold = 1'b1;
        run_txn(16'($urandom), 1'b0);
        chk("guard_start_write", (wr_cyc.size() > 0) ? wr_cyc[0] - start_cyc : -1, 4);
        for (int i = 0; i < 8; i++)
            chk($sformatf("guard_send_write%0d", i),
                (wr_cyc.size() > i + 1 && sd_cyc.size() > i) ?
                wr_cyc[i + 1] - sd_cyc[i] : -1, 4);
        done_hold = 1'b0;

        clear_rec();
        @(negedge ioclk);
        t = 0;
        while (!ready && t < 3000) begin @(negedge ioclk); t++; end
        value = 16'd54321;
        value_valid = 1'b1;
        @(negedge ioclk);
        value_valid = 1'b0;
        t = 0;
        while (n_send < 5 && t < 3000) begin @(negedge ioclk); t++; end
        chk("reached_byte5", n_send, 5);
        res = 1'b0;
        @(negedge ioclk);
        res = 1'b1;
        chk("midreset_pulses", {ready, start, write, send, endcomm}, 0);
        chk("midreset_byte", tx_byte, 0);
        @(negedge ioclk);
        chk("midreset_idle", ready, 1);
        repeat (60) @(negedge ioclk);
        chk("midreset_no_end", n_end, 0);
        chk("midreset_no_write", n_write, 5);
        chk("midreset_no_restart", n_start, 1);

        run_txn(16'd12345, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
